// File: rtl/dp_defs.sv
// Shared definitions for the 16-bit datapath sequencer.
// Holds the opcode map, ALU operation encodings, extender mode constants, the sequencer
// state encoding and the decoded control vector passed from dp_decode to datapath_ctrl.
package dp_defs;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_LDI  = 4'h5;
   localparam logic [3:0] OP_LDS  = 4'h6;
   localparam logic [3:0] OP_ADDI = 4'h7;
   localparam logic [3:0] OP_ANDI = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {
      AluAdd = 2'b00,
      AluSub = 2'b01,
      AluAnd = 2'b10,
      AluOr  = 2'b11
   } alu_op_e;

   localparam logic EXT_ZERO = 1'b0;
   localparam logic EXT_SIGN = 1'b1;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StWb     = 3'd4,
      StHalt   = 3'd5
   } state_e;

   typedef struct packed {
      alu_op_e alu_op;
      logic    alu_src_imm;
      logic    ext_sel;
      logic    writes;
      logic    rs_zero;   // force read port A to r0 (LDI/LDS)
      logic    illegal;
      logic    halt;
   } ctrl_t;

endpackage

// File: rtl/dp_decode.sv
// Combinational opcode decoder.
// Ports:
//   op    in   4   instruction opcode field IR[15:12]
//   ctrl  out  ctrl_t  decoded ALU/extender/write-back controls
// Undefined opcodes decode as NOP with the illegal flag raised.
module dp_decode
   import dp_defs::*;
(
   input  logic [3:0] op,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl             = '0;
      ctrl.alu_op      = AluAdd;
      ctrl.ext_sel     = EXT_ZERO;
      case (op)
         OP_NOP:  ;
         OP_ADD:  ctrl.writes = 1'b1;
         OP_SUB:  begin ctrl.alu_op = AluSub; ctrl.writes = 1'b1; end
         OP_AND:  begin ctrl.alu_op = AluAnd; ctrl.writes = 1'b1; end
         OP_OR:   begin ctrl.alu_op = AluOr;  ctrl.writes = 1'b1; end
         OP_LDI:  begin
            ctrl.alu_src_imm = 1'b1;
            ctrl.writes      = 1'b1;
            ctrl.rs_zero     = 1'b1;
         end
         OP_LDS:  begin
            ctrl.alu_src_imm = 1'b1;
            ctrl.ext_sel     = EXT_SIGN;
            ctrl.writes      = 1'b1;
            ctrl.rs_zero     = 1'b1;
         end
         OP_ADDI: begin
            ctrl.alu_src_imm = 1'b1;
            ctrl.ext_sel     = EXT_SIGN;
            ctrl.writes      = 1'b1;
         end
         OP_ANDI: begin
            ctrl.alu_op      = AluAnd;
            ctrl.alu_src_imm = 1'b1;
            ctrl.writes      = 1'b1;
         end
         OP_HALT: ctrl.halt = 1'b1;
         default: ctrl.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle instruction sequencer for the 16-bit datapath.
// Fetches instructions over a req/ack port and drives register-file, ALU and extender controls.
// Ports:
//   clk, reset (sync, active high), start (1-cycle pulse)
//   imem_req/imem_addr/imem_ack/imem_rdata   instruction fetch handshake
//   rf_raddr_a/rf_raddr_b/rf_waddr/rf_we     register-file controls
//   imm8/ext_sel/alu_src_imm/alu_op          extender and ALU controls
//   busy/halted/illegal_op                   status
module datapath_ctrl
   import dp_defs::*;
#(
   parameter int unsigned PC_W     = 8,
   parameter int unsigned RESET_PC = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [15:0]     imem_rdata,
   output logic [3:0]      rf_raddr_a,
   output logic [3:0]      rf_raddr_b,
   output logic [3:0]      rf_waddr,
   output logic            rf_we,
   output logic [7:0]      imm8,
   output logic            ext_sel,
   output logic            alu_src_imm,
   output logic [1:0]      alu_op,
   output logic            busy,
   output logic            halted,
   output logic            illegal_op
);

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;
   logic            illegal_q, illegal_d;
   logic            load_ctrl;
   ctrl_t           ctrl;

   // Decoded controls, held from DECODE until the next DECODE.
   logic [3:0] raddr_a_q, raddr_b_q, waddr_q;
   logic [7:0] imm8_q;
   logic [1:0] alu_op_q;
   logic       ext_sel_q, alu_src_imm_q, writes_q;

   dp_decode u_decode (
      .op   (ir_q[15:12]),
      .ctrl (ctrl)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      illegal_d = illegal_q;
      load_ctrl = 1'b0;
      case (state_q)
         StIdle, StHalt: begin
            if (start) begin
               state_d   = StFetch;
               pc_d      = PC_W'(RESET_PC);
               illegal_d = 1'b0;
            end
         end
         StFetch: begin
            if (imem_ack) begin
               ir_d    = imem_rdata;
               pc_d    = pc_q + PC_W'(1);
               state_d = StDecode;
            end
         end
         StDecode: begin
            load_ctrl = 1'b1;
            if (ctrl.illegal) illegal_d = 1'b1;
            state_d = ctrl.halt ? StHalt : StExec;
         end
         StExec:  state_d = StWb;
         StWb:    state_d = StFetch;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         pc_q          <= PC_W'(RESET_PC);
         ir_q          <= '0;
         illegal_q     <= 1'b0;
         raddr_a_q     <= '0;
         raddr_b_q     <= '0;
         waddr_q       <= '0;
         imm8_q        <= '0;
         alu_op_q      <= '0;
         ext_sel_q     <= 1'b0;
         alu_src_imm_q <= 1'b0;
         writes_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         illegal_q <= illegal_d;
         if (load_ctrl) begin
            raddr_a_q     <= ctrl.rs_zero ? 4'h0 : ir_q[7:4];
            raddr_b_q     <= ir_q[3:0];
            waddr_q       <= ir_q[11:8];
            imm8_q        <= ir_q[7:0];
            alu_op_q      <= ctrl.alu_op;
            ext_sel_q     <= ctrl.ext_sel;
            alu_src_imm_q <= ctrl.alu_src_imm;
            writes_q      <= ctrl.writes;
         end
      end
   end

   assign imem_req    = (state_q == StFetch);
   assign imem_addr   = pc_q;
   assign rf_raddr_a  = raddr_a_q;
   assign rf_raddr_b  = raddr_b_q;
   assign rf_waddr    = waddr_q;
   assign rf_we       = (state_q == StWb) && writes_q;
   assign imm8        = imm8_q;
   assign ext_sel     = ext_sel_q;
   assign alu_src_imm = alu_src_imm_q;
   assign alu_op      = alu_op_q;
   assign busy        = (state_q == StFetch) || (state_q == StDecode) ||
                        (state_q == StExec)  || (state_q == StWb);
   assign halted      = (state_q == StHalt);
   assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed testbench for datapath_ctrl. Inputs are driven and outputs sampled on the falling edge.
module tb_datapath_ctrl;

   logic        clk = 1'b0;
   logic        reset, start, imem_ack;
   logic [15:0] imem_rdata;
   logic        imem_req, rf_we, ext_sel, alu_src_imm, busy, halted, illegal_op;
   logic [7:0]  imem_addr, imm8;
   logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
   logic [1:0]  alu_op;

   // Narrow-PC instance for the wrap test.
   logic        reset2, start2, imem_ack2;
   logic [15:0] imem_rdata2;
   logic        imem_req2, rf_we2, ext_sel2, alu_src_imm2, busy2, halted2, illegal_op2;
   logic [1:0]  imem_addr2, alu_op2;
   logic [7:0]  imm8_2;
   logic [3:0]  rf_raddr_a2, rf_raddr_b2, rf_waddr2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   datapath_ctrl u_dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .rf_raddr_a  (rf_raddr_a),
      .rf_raddr_b  (rf_raddr_b),
      .rf_waddr    (rf_waddr),
      .rf_we       (rf_we),
      .imm8        (imm8),
      .ext_sel     (ext_sel),
      .alu_src_imm (alu_src_imm),
      .alu_op      (alu_op),
      .busy        (busy),
      .halted      (halted),
      .illegal_op  (illegal_op)
   );

   datapath_ctrl #(
      .PC_W     (2),
      .RESET_PC (3)
   ) u_dut2 (
      .clk         (clk),
      .reset       (reset2),
      .start       (start2),
      .imem_req    (imem_req2),
      .imem_addr   (imem_addr2),
      .imem_ack    (imem_ack2),
      .imem_rdata  (imem_rdata2),
      .rf_raddr_a  (rf_raddr_a2),
      .rf_raddr_b  (rf_raddr_b2),
      .rf_waddr    (rf_waddr2),
      .rf_we       (rf_we2),
      .imm8        (imm8_2),
      .ext_sel     (ext_sel2),
      .alu_src_imm (alu_src_imm2),
      .alu_op      (alu_op2),
      .busy        (busy2),
      .halted      (halted2),
      .illegal_op  (illegal_op2)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Entered at a falling edge while in FETCH; returns in DECODE.
   task automatic do_fetch(input logic [15:0] instr, input int delay, input logic [7:0] exp_addr,
                           output int req_cycles);
      req_cycles = 0;
      for (int i = 0; i < delay; i++) begin
         if (imem_req) req_cycles++;
         check("fetch_addr_wait", 16'(imem_addr), 16'(exp_addr));
         tick();
      end
      if (imem_req) req_cycles++;
      check("fetch_addr", 16'(imem_addr), 16'(exp_addr));
      imem_ack   = 1'b1;
      imem_rdata = instr;
      tick();
      imem_ack   = 1'b0;
      imem_rdata = 16'h0;
      check("decode_req", 16'(imem_req), 16'h0);
   endtask

   // Entered in DECODE; returns in the following FETCH.
   task automatic finish_instr(input logic exp_we, input logic [3:0] exp_waddr);
      tick();
      check("exec_we", 16'(rf_we), 16'h0);
      tick();
      check("wb_we", 16'(rf_we), 16'(exp_we));
      if (exp_we) check("wb_waddr", 16'(rf_waddr), 16'(exp_waddr));
      tick();
      check("next_fetch_req", 16'(imem_req), 16'h1);
      check("next_fetch_we", 16'(rf_we), 16'h0);
   endtask

   initial begin
      int n;
      reset = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0;
      reset2 = 1'b1; start2 = 1'b0; imem_ack2 = 1'b0; imem_rdata2 = 16'h0;
      tick();
      tick();
      // Reset state
      check("rst_req", 16'(imem_req), 16'h0);
      check("rst_addr", 16'(imem_addr), 16'h0);
      check("rst_busy", 16'(busy), 16'h0);
      check("rst_halted", 16'(halted), 16'h0);
      check("rst_we", 16'(rf_we), 16'h0);
      check("rst_illegal", 16'(illegal_op), 16'h0);

      // 1: start -> FETCH at 0
      reset = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t1_req", 16'(imem_req), 16'h1);
      check("t1_addr", 16'(imem_addr), 16'h0);
      check("t1_busy", 16'(busy), 16'h1);
      check("t1_we", 16'(rf_we), 16'h0);
      check("t1_src_imm", 16'(alu_src_imm), 16'h0);
      check("t1_waddr", 16'(rf_waddr), 16'h0);
      check("t1_imm8", 16'(imm8), 16'h0);

      // 2: LDI r10,0x80 with immediate ack
      do_fetch(16'h5A80, 0, 8'h00, n);
      tick();
      check("t2_raddr_a", 16'(rf_raddr_a), 16'h0);
      check("t2_src_imm", 16'(alu_src_imm), 16'h1);
      check("t2_ext_sel", 16'(ext_sel), 16'h0);
      check("t2_imm8", 16'(imm8), 16'h80);
      check("t2_exec_we", 16'(rf_we), 16'h0);
      tick();
      check("t2_wb_we", 16'(rf_we), 16'h1);
      check("t2_waddr", 16'(rf_waddr), 16'hA);
      tick();
      check("t2_pc", 16'(imem_addr), 16'h1);
      check("t2_we_off", 16'(rf_we), 16'h0);

      // 3: LDS r3,0x80 with ack after 5 wait cycles
      do_fetch(16'h6380, 5, 8'h01, n);
      check("t3_req_cycles", 16'(n), 16'd6);
      tick();
      check("t3_ext_sel", 16'(ext_sel), 16'h1);
      check("t3_raddr_a", 16'(rf_raddr_a), 16'h0);
      check("t3_alu_op", 16'(alu_op), 16'h0);
      tick();
      check("t3_wb_we", 16'(rf_we), 16'h1);
      check("t3_waddr", 16'(rf_waddr), 16'h3);
      tick();
      check("t3_we_off", 16'(rf_we), 16'h0);
      check("t3_pc", 16'(imem_addr), 16'h2);

      // 4: ADD r1,r2,r3 ; NOP ; HALT
      do_fetch(16'h1123, 0, 8'h02, n);
      tick();
      check("t4_raddr_a", 16'(rf_raddr_a), 16'h2);
      check("t4_raddr_b", 16'(rf_raddr_b), 16'h3);
      check("t4_src_imm", 16'(alu_src_imm), 16'h0);
      check("t4_alu_op", 16'(alu_op), 16'h0);
      tick();
      check("t4_add_we", 16'(rf_we), 16'h1);
      check("t4_add_waddr", 16'(rf_waddr), 16'h1);
      tick();
      do_fetch(16'h0000, 1, 8'h03, n);
      finish_instr(1'b0, 4'h0);
      do_fetch(16'hF000, 0, 8'h04, n);
      tick();
      check("t4_halted", 16'(halted), 16'h1);
      check("t4_halt_req", 16'(imem_req), 16'h0);
      check("t4_halt_busy", 16'(busy), 16'h0);
      check("t4_halt_we", 16'(rf_we), 16'h0);
      tick();
      check("t4_halt_hold", 16'(halted), 16'h1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t4_restart_req", 16'(imem_req), 16'h1);
      check("t4_restart_addr", 16'(imem_addr), 16'h0);
      check("t4_restart_halted", 16'(halted), 16'h0);

      // 5: illegal opcode, sticky until start
      do_fetch(16'h9123, 0, 8'h00, n);
      tick();
      check("t5_illegal", 16'(illegal_op), 16'h1);
      tick();
      check("t5_wb_we", 16'(rf_we), 16'h0);
      tick();
      check("t5_pc", 16'(imem_addr), 16'h1);
      do_fetch(16'h1456, 0, 8'h01, n);
      finish_instr(1'b1, 4'h4);
      check("t5_sticky", 16'(illegal_op), 16'h1);
      do_fetch(16'hF000, 0, 8'h02, n);
      tick();
      check("t5_halted", 16'(halted), 16'h1);
      check("t5_sticky_halt", 16'(illegal_op), 16'h1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t5_cleared", 16'(illegal_op), 16'h0);
      check("t5_addr", 16'(imem_addr), 16'h0);

      // 6b: reset during EXEC of ADD aborts write-back
      do_fetch(16'h1789, 0, 8'h00, n);
      tick();
      check("t6_exec_busy", 16'(busy), 16'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_rst_we", 16'(rf_we), 16'h0);
      check("t6_rst_busy", 16'(busy), 16'h0);
      check("t6_rst_req", 16'(imem_req), 16'h0);
      check("t6_rst_pc", 16'(imem_addr), 16'h0);
      check("t6_rst_waddr", 16'(rf_waddr), 16'h0);
      tick();
      check("t6_idle_we", 16'(rf_we), 16'h0);
      check("t6_idle_busy", 16'(busy), 16'h0);

      // 6a: PC_W=2 wraps 3 -> 0
      reset2 = 1'b0;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         logic [1:0] exp_pc;
         exp_pc = 2'(3 + k);
         check("t6_wrap_addr", 16'(imem_addr2), 16'(exp_pc));
         check("t6_wrap_req", 16'(imem_req2), 16'h1);
         imem_ack2   = 1'b1;
         imem_rdata2 = 16'h0000;
         tick();
         imem_ack2 = 1'b0;
         tick();
         tick();
         check("t6_wrap_we", 16'(rf_we2), 16'h0);
         tick();
      end
      check("t6_wrap_final", 16'(imem_addr2), 16'h3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
